// File: rtl/rv_scoreboard_pkg.sv
// ---------------------------------------------------------------------------
// rv_scoreboard_pkg
// Shared sizing, operand-slot indices and small helpers for the register
// scoreboard slice (rv_scoreboard, rv_stall_watchdog).
//   NUM_WARPS / NW_BITS : warp count and warp-id width
//   NUM_REGS  / NR_BITS : registers per warp (2^NR_BITS) and register-id width
//   CNT_BITS            : width of the in-use population counter
//   REG_RD..REG_RS3     : bit positions inside the 4-bit used_regs mask
// ---------------------------------------------------------------------------
package rv_scoreboard_pkg;

  localparam int NUM_WARPS = 4;
  localparam int NW_BITS   = $clog2(NUM_WARPS);
  localparam int NR_BITS   = 5;
  localparam int NUM_REGS  = 1 << NR_BITS;

  // Enough bits to count every in-use flag of every warp.
  localparam int CNT_BITS  = NR_BITS + NW_BITS + 1;

  // Operand slots of the used_regs mask {rs3, rs2, rs1, rd}.
  localparam int REG_RD  = 0;
  localparam int REG_RS1 = 1;
  localparam int REG_RS2 = 2;
  localparam int REG_RS3 = 3;

  typedef logic [NW_BITS-1:0]  wid_t;
  typedef logic [NR_BITS-1:0]  reg_t;
  typedef logic [NUM_REGS-1:0] regmask_t;

  // One-hot register mask, used for the writeback release bypass.
  function automatic regmask_t reg_onehot(input reg_t r);
    regmask_t m;
    m    = '0;
    m[r] = 1'b1;
    return m;
  endfunction

endpackage

// File: rtl/rv_stall_watchdog.sv
// ---------------------------------------------------------------------------
// rv_stall_watchdog
// Counts consecutive stalled issue cycles and raises a sticky deadlock flag
// on the DEADLOCK_CYCLES-th consecutive stall cycle.
//   clk, reset  : clock, synchronous active-high reset
//   i_stall     : head instruction valid but blocked this cycle
//   o_deadlock  : sticky until reset
// The counter saturates at all-ones instead of wrapping.
// ---------------------------------------------------------------------------
module rv_stall_watchdog
  import rv_scoreboard_pkg::*;
#(
  parameter int DEADLOCK_CYCLES = 10000,
  parameter int CNTW            = 16
) (
  input  logic clk,
  input  logic reset,
  input  logic i_stall,
  output logic o_deadlock
);

  // The counter holds the number of stall cycles before the current one, so
  // it reads DEADLOCK_CYCLES-1 during the DEADLOCK_CYCLES-th stall cycle.
  localparam logic [CNTW-1:0] TRIP_AT = CNTW'(DEADLOCK_CYCLES - 1);

  logic [CNTW-1:0] r_cnt;
  logic            r_deadlock;
  logic            w_trip;
  logic            w_sat;

  assign w_sat  = &r_cnt;
  assign w_trip = i_stall & ~reset & (r_cnt == TRIP_AT);

  always_ff @(posedge clk) begin
    if (reset) begin
      r_cnt      <= '0;
      r_deadlock <= 1'b0;
    end else begin
      if (!i_stall) begin
        r_cnt <= '0;
      end else if (!w_sat) begin
        r_cnt <= r_cnt + CNTW'(1);
      end
      if (w_trip) begin
        r_deadlock <= 1'b1;
      end
    end
  end

  // Combinational trip term lets the flag show in the trip cycle itself;
  // the register keeps it asserted afterwards.
  assign o_deadlock = r_deadlock | w_trip;

endmodule

// File: rtl/rv_scoreboard.sv
// ---------------------------------------------------------------------------
// rv_scoreboard
// Register-hazard tracker between instruction buffer and dispatch. One
// in-use bit per (warp, register): set when an rd-writing instruction
// issues, cleared when writeback retires that rd on its end-of-packet beat.
// Issue is held off while any checked operand of the head instruction is
// pending. A retiring register is bypassed so a same-cycle consumer issues.
// Ports:
//   clk, reset                 : clock, synchronous active-high reset
//   ibuf_valid/wid/rd/rs1..3   : head instruction
//   ibuf_used_regs             : {rs3,rs2,rs1,rd} operands to check
//   ibuf_wb                    : instruction writes rd
//   ibuf_ready                 : no hazard (combinational)
//   writeback_valid/ready      : writeback handshake (ready only observed)
//   writeback_wid/rd/eop       : retiring register, last beat marker
//   inuse_count                : registered number of set in-use bits
//   deadlock                   : sticky stall-watchdog flag
// ---------------------------------------------------------------------------
module rv_scoreboard
  import rv_scoreboard_pkg::*;
#(
  parameter int CORE_ID         = 0,
  parameter int DEADLOCK_CYCLES = 10000,
  parameter int CNTW            = 16
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                ibuf_valid,
  input  wid_t                ibuf_wid,
  input  reg_t                ibuf_rd,
  input  reg_t                ibuf_rs1,
  input  reg_t                ibuf_rs2,
  input  reg_t                ibuf_rs3,
  input  logic [3:0]          ibuf_used_regs,
  input  logic                ibuf_wb,
  output logic                ibuf_ready,
  input  logic                writeback_valid,
  input  logic                writeback_ready,
  input  wid_t                writeback_wid,
  input  reg_t                writeback_rd,
  input  logic                writeback_eop,
  output logic [CNT_BITS-1:0] inuse_count,
  output logic                deadlock
);

  logic [NUM_WARPS-1:0][NUM_REGS-1:0] r_inuse;
  logic [NUM_WARPS-1:0][NUM_REGS-1:0] w_inuse_next;
  logic [CNT_BITS-1:0]                r_inuse_count;

  logic     w_issue_fire;
  logic     w_release_fire;
  logic     w_set;
  regmask_t w_release_mask;
  regmask_t w_eff_inuse;
  logic     w_hazard;
  logic     w_stall;
  logic     w_set_was;
  logic     w_clr_was;
  logic     w_same;
  logic     w_inc;
  logic     w_dec;

  assign w_release_fire = writeback_valid & writeback_ready & writeback_eop;

  // Bypass: a register retiring this cycle no longer blocks the head
  // instruction of the same warp.
  assign w_release_mask = (w_release_fire && (writeback_wid == ibuf_wid))
                          ? reg_onehot(writeback_rd) : '0;
  assign w_eff_inuse    = r_inuse[ibuf_wid] & ~w_release_mask;

  assign w_hazard = (ibuf_used_regs[REG_RD]  & w_eff_inuse[ibuf_rd])
                  | (ibuf_used_regs[REG_RS1] & w_eff_inuse[ibuf_rs1])
                  | (ibuf_used_regs[REG_RS2] & w_eff_inuse[ibuf_rs2])
                  | (ibuf_used_regs[REG_RS3] & w_eff_inuse[ibuf_rs3]);

  assign ibuf_ready   = ~w_hazard;
  assign w_issue_fire = ibuf_valid & ibuf_ready & ~reset;

  // x0 is hardwired zero and never becomes a pending producer.
  assign w_set = w_issue_fire & ibuf_wb & (ibuf_rd != '0);

  // Clear first, then set, so a new producer wins over a same-cycle retire.
  always_comb begin
    w_inuse_next = r_inuse;
    if (w_release_fire) begin
      w_inuse_next[writeback_wid][writeback_rd] = 1'b0;
    end
    if (w_set) begin
      w_inuse_next[ibuf_wid][ibuf_rd] = 1'b1;
    end
  end

  // Population tracking from actual bit transitions: a set only counts if the
  // bit was clear, a clear only if the bit was set and is not re-set.
  assign w_set_was = r_inuse[ibuf_wid][ibuf_rd];
  assign w_clr_was = r_inuse[writeback_wid][writeback_rd];
  assign w_same    = (ibuf_wid == writeback_wid) && (ibuf_rd == writeback_rd);
  assign w_inc     = w_set & ~w_set_was;
  assign w_dec     = w_release_fire & w_clr_was & ~(w_set & w_same);

  always_ff @(posedge clk) begin
    if (reset) begin
      r_inuse       <= '0;
      r_inuse_count <= '0;
    end else begin
      r_inuse       <= w_inuse_next;
      r_inuse_count <= r_inuse_count + CNT_BITS'(w_inc) - CNT_BITS'(w_dec);
    end
  end

  assign inuse_count = r_inuse_count;

  assign w_stall = ibuf_valid & ~ibuf_ready;

  rv_stall_watchdog #(
    .DEADLOCK_CYCLES (DEADLOCK_CYCLES),
    .CNTW            (CNTW)
  ) u_watchdog (
    .clk        (clk),
    .reset      (reset),
    .i_stall    (w_stall),
    .o_deadlock (deadlock)
  );

`ifndef SYNTHESIS
  // Retiring a register that is not pending points at a lost or duplicated
  // writeback upstream; the state itself is unaffected.
  always_ff @(posedge clk) begin
    if (!reset && w_release_fire) begin
      assert (w_clr_was)
        else $error("rv_scoreboard core %0d: retire of idle register w%0d r%0d",
                    CORE_ID, writeback_wid, writeback_rd);
    end
  end
`endif

endmodule
